// File: rtl/core_pkg.sv
// Shared types and helpers for the data-memory access path: FSM states,
// funct3 encodings, byte-enable patterns and store-side data positioning.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unsupported size encodings fall through to "misaligned" so they never reach the bus.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_B, F3_BU: return 1'b1;
            F3_H, F3_HU: return ~offset[0];
            F3_W:        return (offset == 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_B, F3_BU: return BE_BYTE << offset;
            F3_H, F3_HU: return BE_HALF << offset;
            default:     return BE_WORD;
        endcase
    endfunction

    // Replicating the store operand puts it in every lane; the byte enables pick the real one.
    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3)
            F3_B, F3_BU: return {4{wdata[7:0]}};
            F3_H, F3_HU: return {2{wdata[15:0]}};
            default:     return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/halfword from a bus word and sign- or
// zero-extends it to 32 bits. Purely combinational.
module load_extend
    import core_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by size/sign extension.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        byte_sel = word[7:0];
        data     = word;
        case (offset)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit front end: turns a core memory strobe into a
// req/gnt/rvalid bus transaction, stalls the pipeline while it is in
// flight, and aborts with bus_err_o if the bus does not answer in time.
module data_mem_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memrd_i,
    input  logic              memw_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [2:0]        funct3_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i
);

    // Counter only has to hold 0..TIMEOUT_CYCLES-1; the abort fires on the last value.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state;
    logic [CNT_W-1:0] count;
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic [31:0]      load_data;
    logic             req_seen;
    logic             aligned;
    logic             timeout_hit;
    logic             store_done;
    logic             load_done;

    load_extend u_load_extend (
        .word   (bus_rdata_i),
        .offset (offset_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // Request decode, completion detection and the pipeline stall.
    always_comb begin
        req_seen    = memrd_i | memw_i;
        aligned     = is_aligned(funct3_i, addr_i[1:0]);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (count == CNT_LAST);
        store_done  = (state == REQ) && bus_gnt_i && bus_we_o;
        load_done   = (state == WAIT) && bus_rvalid_i;
        case (state)
            IDLE:    stall_o = req_seen & aligned;
            REQ:     stall_o = ~store_done & ~(timeout_hit & ~bus_gnt_i);
            WAIT:    stall_o = ~load_done & ~timeout_hit;
            default: stall_o = 1'b0;
        endcase
    end

    // Transaction FSM with registered bus fields and one-cycle status pulses.
    // A bus response in the final timeout cycle wins over the abort.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state       <= IDLE;
            count       <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
            rdata_o     <= '0;
            rvalid_o    <= 1'b0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
        end else begin
            rvalid_o   <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_seen) begin
                        if (aligned) begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= memw_i;
                            bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                            bus_be_o    <= byte_enables(funct3_i, addr_i[1:0]);
                            bus_wdata_o <= store_data(funct3_i, wdata_i);
                            funct3_q    <= funct3_i;
                            offset_q    <= addr_i[1:0];
                            count       <= '0;
                            state       <= REQ;
                        end else begin
                            misalign_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        count     <= count + 1'b1;
                        state     <= bus_we_o ? IDLE : WAIT;
                    end else if (timeout_hit) begin
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        rdata_o   <= '0;
                        state     <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        rdata_o  <= load_data;
                        rvalid_o <= 1'b1;
                        state    <= IDLE;
                    end else if (timeout_hit) begin
                        bus_err_o <= 1'b1;
                        rdata_o   <= '0;
                        state     <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: each stimulus pushes the bus fields
// and completion event it should cause; a negedge monitor pops and compares.
module tb_data_mem_ctrl;
    import core_pkg::*;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        memrd_i, memw_i;
    logic [31:0] addr_i, wdata_i;
    logic [2:0]  funct3_i;
    logic        stall_o, rvalid_o, misalign_o, bus_err_o;
    logic [31:0] rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    always #5 clk_i = ~clk_i;

    data_mem_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .memrd_i      (memrd_i),
        .memw_i       (memw_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .funct3_i     (funct3_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    typedef enum {R_LOAD, R_MIS, R_ERR} rkind_e;
    typedef struct { rkind_e kind; logic [31:0] data; } resp_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic act, input logic exp);
        check(tag, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [2:0] kind_bits(input rkind_e k);
        case (k)
            R_LOAD:  return 3'b100;
            R_MIS:   return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    // Monitor: bus handshakes and completion pulses are compared against the queues.
    always @(negedge clk_i) begin
        bus_t  eb;
        resp_t er;
        if (bus_req_o && bus_gnt_i) begin
            if (bus_q.size() == 0) begin
                check_bit("bus_unexpected", 1'b1, 1'b0);
            end else begin
                eb = bus_q.pop_front();
                check("bus_addr", bus_addr_o, eb.addr);
                check_bit("bus_we", bus_we_o, eb.we);
                check({"bus_be"}, {28'h0, bus_be_o}, {28'h0, eb.be});
                if (eb.we) check("bus_wdata", bus_wdata_o, eb.wdata);
            end
        end
        if (rvalid_o || misalign_o || bus_err_o) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", {29'h0, rvalid_o, misalign_o, bus_err_o}, 32'h0);
            end else begin
                er = resp_q.pop_front();
                check("resp_kind", {29'h0, rvalid_o, misalign_o, bus_err_o}, {29'h0, kind_bits(er.kind)});
                if (er.kind != R_MIS) check("resp_rdata", rdata_o, er.data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic queues_empty(input string tag);
        check({tag, "_busq"}, 32'(bus_q.size()), 32'h0);
        check({tag, "_respq"}, 32'(resp_q.size()), 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, rdata_o, 32'h0);
        check({tag, "_pulses"}, {29'h0, rvalid_o, misalign_o, bus_err_o}, 32'h0);
        check({tag, "_req_we"}, {30'h0, bus_req_o, bus_we_o}, 32'h0);
        check({tag, "_addr"}, bus_addr_o, 32'h0);
        check({tag, "_be"}, {28'h0, bus_be_o}, 32'h0);
        check({tag, "_wdata"}, bus_wdata_o, 32'h0);
        check_bit({tag, "_stall"}, stall_o, 1'b0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input int gd,
                           input logic [31:0] rd, input logic [31:0] exp, input logic [3:0] be);
        memrd_i = 1'b1; addr_i = a; funct3_i = f3;
        bus_q.push_back('{a & 32'hFFFF_FFFC, 1'b0, be, 32'h0});
        resp_q.push_back('{R_LOAD, exp});
        neg(); check_bit("ld_stall_idle", stall_o, 1'b1);
        cyc(); memrd_i = 1'b0;
        for (int i = 0; i < gd; i++) begin
            neg(); check_bit("ld_stall_req", stall_o, 1'b1);
            check_bit("ld_req_held", bus_req_o, 1'b1);
            cyc();
        end
        bus_gnt_i = 1'b1;
        neg(); check_bit("ld_stall_gnt", stall_o, 1'b1);
        cyc(); bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = rd;
        neg(); check_bit("ld_stall_rv", stall_o, 1'b0);
        check_bit("ld_req_dropped", bus_req_o, 1'b0);
        cyc(); bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        neg(); check_bit("ld_stall_done", stall_o, 1'b0);
        cyc();
        queues_empty("ld");
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                            input int gd, input logic also_rd,
                            input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd);
        memw_i = 1'b1; memrd_i = also_rd; addr_i = a; funct3_i = f3; wdata_i = wd;
        bus_q.push_back('{ea, 1'b1, ebe, ewd});
        neg(); check_bit("st_stall_idle", stall_o, 1'b1);
        cyc(); memw_i = 1'b0; memrd_i = 1'b0;
        for (int i = 0; i < gd; i++) begin
            neg(); check_bit("st_stall_req", stall_o, 1'b1);
            cyc();
        end
        bus_gnt_i = 1'b1;
        neg(); check_bit("st_stall_gnt", stall_o, 1'b0);
        cyc(); bus_gnt_i = 1'b0;
        neg(); check_bit("st_req_dropped", bus_req_o, 1'b0);
        check_bit("st_stall_after", stall_o, 1'b0);
        cyc(); cyc();
        queues_empty("st");
    endtask

    task automatic do_misalign(input logic [31:0] a, input logic [2:0] f3, input logic we);
        memrd_i = ~we; memw_i = we; addr_i = a; funct3_i = f3;
        resp_q.push_back('{R_MIS, 32'h0});
        neg(); check_bit("mis_stall", stall_o, 1'b0);
        cyc(); memrd_i = 1'b0; memw_i = 1'b0;
        neg(); check_bit("mis_no_req", bus_req_o, 1'b0);
        check_bit("mis_stall_after", stall_o, 1'b0);
        cyc(); cyc();
        queues_empty("mis");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; memrd_i = 1'b0; memw_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
        funct3_i = F3_W; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        cyc(); cyc();
        neg(); check_all_zero("reset");
        cyc(); rst_i = 1'b0; cyc();

        // Loads: word, sign/zero-extended bytes and halves.
        do_load(32'h104, F3_W,  2, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
        do_load(32'h103, F3_B,  0, 32'h80FFFFFF, 32'hFFFFFF80, 4'b1000);
        do_load(32'h103, F3_BU, 1, 32'h80FFFFFF, 32'h00000080, 4'b1000);
        do_load(32'h102, F3_HU, 0, 32'h80FFFFFF, 32'h000080FF, 4'b1100);
        do_load(32'h100, F3_H,  0, 32'h12348001, 32'hFFFF8001, 4'b0011);
        do_load(32'h101, F3_BU, 0, 32'h1234A5C3, 32'h000000A5, 4'b0010);

        // Stores: lane enables and replicated data.
        do_store(32'h201, F3_B, 32'h000000AB, 0, 1'b0, 32'h200, 4'b0010, 32'hABABABAB);
        do_store(32'h202, F3_H, 32'h0000CDEF, 2, 1'b0, 32'h200, 4'b1100, 32'hCDEFCDEF);
        do_store(32'h204, F3_W, 32'hCAFEF00D, 1, 1'b0, 32'h204, 4'b1111, 32'hCAFEF00D);

        // Both strobes high: the store must win and no load completes.
        do_store(32'h300, F3_W, 32'h12345678, 0, 1'b1, 32'h300, 4'b1111, 32'h12345678);

        // Misaligned and unsupported encodings.
        do_misalign(32'h102, F3_W, 1'b0);
        do_misalign(32'h103, F3_H, 1'b1);
        do_misalign(32'h100, 3'b011, 1'b0);

        // Timeout: rdata_o is non-zero from an earlier load and must be cleared.
        memrd_i = 1'b1; addr_i = 32'h110; funct3_i = F3_W;
        resp_q.push_back('{R_ERR, 32'h0});
        neg(); check_bit("to_stall_idle", stall_o, 1'b1);
        cyc(); memrd_i = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            neg();
            check_bit("to_stall_req", stall_o, (i < TO));
            check_bit("to_req_held", bus_req_o, 1'b1);
            cyc();
        end
        neg(); check_bit("to_req_dropped", bus_req_o, 1'b0);
        check_bit("to_stall_after", stall_o, 1'b0);
        cyc(); cyc();
        queues_empty("to");

        // Reset in the middle of REQ: everything clears, no pulses follow.
        memrd_i = 1'b1; addr_i = 32'h120; funct3_i = F3_W;
        neg(); cyc(); memrd_i = 1'b0;
        neg(); check_bit("rst_req_pre", bus_req_o, 1'b1);
        cyc(); rst_i = 1'b1;
        neg(); cyc(); rst_i = 1'b0;
        neg(); check_all_zero("rst_mid");
        for (int i = 0; i < TO + 2; i++) begin
            cyc(); neg(); check_bit("rst_quiet_req", bus_req_o, 1'b0);
        end
        cyc();
        queues_empty("rst");

        // Controller still works after the mid-transaction reset.
        do_load(32'h108, F3_W, 0, 32'h0BADF00D, 32'h0BADF00D, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
